imm_field_encoder: RTL and testbench

- Inverse of the immediate sign/zero-extension path: takes a 16-bit value and a target immediate format and packs it into the 9-bit instruction immediate field.
- Flags values that the selected format cannot represent.
- Used by the program loader/self-modifying-code path and by the debug patch unit to build instruction words.
- Valid/ready on both sides, a 2-entry result buffer, and sticky overflow statistics.

---
 rtl/imm_field_encoder_if.sv | 16 +
 rtl/imm_field_encoder.sv | 60 ++++++
 tb/tb_imm_field_encoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/imm_field_encoder_if.sv
// imm_field_encoder_if: request/result handshake bundle for the immediate encoder
interface imm_field_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_imm;
  logic [1:0]  out_sel;
  logic        out_ovf;
  modport master(output in_valid, in_value, in_sel, out_ready,
                 input in_ready, out_valid, out_imm, out_sel, out_ovf);
  modport slave(input in_valid, in_value, in_sel, out_ready,
                output in_ready, out_valid, out_imm, out_sel, out_ovf);
endinterface

// File: rtl/imm_field_encoder.sv
// imm_field_encoder: packs a 16-bit value into a 9-bit immediate field, 2-entry result FIFO, overflow stats
module imm_field_encoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_field_encoder_if.slave bus,
  input  logic               clr_stats,
  output logic               sticky_ovf,
  output logic [COUNT_W-1:0] ovf_count
);
  logic [15:0] v;
  logic [1:0]  sel;
  logic        ovf;
  logic [8:0]  imm;
  logic [11:0] mem [2];
  logic        head;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        wr;
  assign v   = bus.in_value;
  assign sel = bus.in_sel;
  // a signed field overflows when the discarded bits and the sign bit are not all equal
  assign ovf = (sel == 2'b00) ? (|v[15:8] && !(&v[15:8])) :
               (sel == 2'b01) ? (|v[15:7] && !(&v[15:7])) :
               (sel == 2'b10) ? (|v[15:5] && !(&v[15:5])) : |v[15:9];
  assign imm = (sel == 2'b01) ? {1'b0, v[7:0]} :
               (sel == 2'b10) ? {3'b000, v[5:0]} : v[8:0];
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign {bus.out_imm, bus.out_sel, bus.out_ovf} = mem[head];
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  assign wr   = head ^ count[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr] <= {imm, sel, ovf};
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_stats) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (push && ovf) begin
      sticky_ovf <= 1'b1;
      ovf_count  <= (&ovf_count) ? ovf_count : ovf_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_field_encoder.sv
// tb_imm_field_encoder: table-driven encoding checks plus backpressure, throughput, stats and reset sequences
module tb_imm_field_encoder;
  localparam int COUNT_W = 2;
  localparam int CNT_MAX = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_stats = 1'b0;
  logic sticky_ovf;
  logic [COUNT_W-1:0] ovf_count;
  int pass = 0;
  int total = 0;
  int exp_cnt = 0;
  logic exp_sticky = 1'b0;
  imm_field_encoder_if bus();
  imm_field_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .clr_stats(clr_stats), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] value;
    logic [1:0]  sel;
    logic [8:0]  imm;
    logic        ovf;
  } vec_t;
  vec_t vecs [14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic model_accept(input logic ovf);
    if (clr_stats) begin
      exp_cnt = 0;
      exp_sticky = 1'b0;
    end else if (ovf) begin
      exp_sticky = 1'b1;
      if (exp_cnt < CNT_MAX) exp_cnt++;
    end
  endtask
  task automatic check_stats(input string tag);
    check({tag, " ovf_count"}, 32'(ovf_count), 32'(exp_cnt));
    check({tag, " sticky"}, 32'(sticky_ovf), 32'(exp_sticky));
  endtask
  initial begin
    vecs[0]  = '{16'hFF00, 2'b00, 9'h100, 1'b0};
    vecs[1]  = '{16'h0100, 2'b00, 9'h100, 1'b1};
    vecs[2]  = '{16'h007F, 2'b01, 9'h07F, 1'b0};
    vecs[3]  = '{16'hFF80, 2'b01, 9'h080, 1'b0};
    vecs[4]  = '{16'h0080, 2'b01, 9'h080, 1'b1};
    vecs[5]  = '{16'h001F, 2'b10, 9'h01F, 1'b0};
    vecs[6]  = '{16'hFFE0, 2'b10, 9'h020, 1'b0};
    vecs[7]  = '{16'hFFDF, 2'b10, 9'h01F, 1'b1};
    vecs[8]  = '{16'h01FF, 2'b11, 9'h1FF, 1'b0};
    vecs[9]  = '{16'h0200, 2'b11, 9'h000, 1'b1};
    vecs[10] = '{16'hFFFF, 2'b11, 9'h1FF, 1'b1};
    vecs[11] = '{16'h00FF, 2'b00, 9'h0FF, 1'b0};
    vecs[12] = '{16'hFF00, 2'b01, 9'h000, 1'b1};
    vecs[13] = '{16'h1234, 2'b00, 9'h034, 1'b1};
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_sel = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset out_imm", 32'(bus.out_imm), 0);
    check("reset out_sel", 32'(bus.out_sel), 0);
    check("reset out_ovf", 32'(bus.out_ovf), 0);
    check_stats("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_value = vecs[i].value;
      bus.in_sel = vecs[i].sel;
      model_accept(vecs[i].ovf);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 1);
      check($sformatf("vec%0d out_imm", i), 32'(bus.out_imm), 32'(vecs[i].imm));
      check($sformatf("vec%0d out_sel", i), 32'(bus.out_sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d out_ovf", i), 32'(bus.out_ovf), 32'(vecs[i].ovf));
      check_stats($sformatf("vec%0d", i));
    end
    // backpressure: A and B fill the buffer, C must wait
    @(negedge clk);
    check("bp idle out_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_value = 16'h0005;
    bus.in_sel = 2'b00;
    @(negedge clk);
    bus.in_value = 16'hFFFE;
    @(negedge clk);
    check("bp full in_ready", 32'(bus.in_ready), 0);
    check("bp head A", 32'(bus.out_imm), 32'h005);
    bus.in_value = 16'h0003;
    bus.in_sel = 2'b01;
    @(negedge clk);
    check("bp stall in_ready", 32'(bus.in_ready), 0);
    check("bp stall valid", 32'(bus.out_valid), 1);
    check("bp stall head A", 32'(bus.out_imm), 32'h005);
    check("bp stall sel A", 32'(bus.out_sel), 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp head B", 32'(bus.out_imm), 32'h1FE);
    check("bp after pop in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp head C", 32'(bus.out_imm), 32'h003);
    check("bp sel C", 32'(bus.out_sel), 1);
    @(negedge clk);
    check("bp drained", 32'(bus.out_valid), 0);
    // throughput: one result per cycle, never fills
    bus.in_sel = 2'b00;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_value = 16'(i + 8);
      @(negedge clk);
      check($sformatf("tp%0d imm", i), 32'(bus.out_imm), 32'(i + 8));
      check($sformatf("tp%0d in_ready", i), 32'(bus.in_ready), 1);
      check($sformatf("tp%0d out_valid", i), 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("tp drained", 32'(bus.out_valid), 0);
    // clear wins over a same-cycle overflowing accept
    check_stats("pre-clr");
    bus.in_valid = 1'b1;
    bus.in_value = 16'h0100;
    bus.in_sel = 2'b00;
    clr_stats = 1'b1;
    model_accept(1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr_stats = 1'b0;
    check_stats("clr+ovf");
    check("clr entry ovf", 32'(bus.out_ovf), 1);
    check("clr entry valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    // async reset with two buffered entries
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_value = 16'h0100;
    model_accept(1'b1);
    @(negedge clk);
    bus.in_value = 16'h0200;
    bus.in_sel = 2'b11;
    model_accept(1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre-rst in_ready", 32'(bus.in_ready), 0);
    check_stats("pre-rst");
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_sticky = 1'b0;
    check("arst out_valid", 32'(bus.out_valid), 0);
    check("arst in_ready", 32'(bus.in_ready), 1);
    check("arst out_imm", 32'(bus.out_imm), 0);
    check_stats("arst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = 16'hFFF0;
    bus.in_sel = 2'b10;
    model_accept(1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("post-rst valid", 32'(bus.out_valid), 1);
    check("post-rst imm", 32'(bus.out_imm), 32'h030);
    check("post-rst ovf", 32'(bus.out_ovf), 0);
    check_stats("post-rst");
    @(negedge clk);
    check("post-rst drained", 32'(bus.out_valid), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
